icache_sa: RTL

Parametrised N-way set-associative instruction cache, the successor to the direct-mapped 4KB instruction cache in the fetch path. It sits between the fetch stage and the memory port, with valid/ready request/response handshakes and a whole-cache flush. Misses fill the line in order, word 0 first, and replacement uses a per-set round-robin victim pointer.

---
 rtl/icache_sa_pkg.sv | 26 ++
 rtl/icache_victim_sel.sv | 21 ++
 rtl/icache_sa.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/icache_sa_pkg.sv
// Shared types and width helpers for the set-associative instruction cache.
// The optional hit/miss counters are built only when ICACHE_SA_PERF_EN is defined.
package icache_sa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_FILL,
        ST_RESP,
        ST_FLUSH
    } state_t;

    function automatic int set_width(int cache_size, int line_size, int ways);
        return $clog2(cache_size / (line_size * ways));
    endfunction

    function automatic int off_width(int line_size);
        return $clog2(line_size / 4);
    endfunction

    // A direct-mapped build still needs a 1-bit way index to keep vectors legal.
    function automatic int way_width(int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/icache_victim_sel.sv
// Replacement choice for one set: lowest invalid way, else the round-robin pointer.
module icache_victim_sel #(
    parameter int WAYS  = 2,
    parameter int WAY_W = 1
) (
    input  logic [WAYS-1:0]  valid,
    input  logic [WAY_W-1:0] ptr,
    output logic [WAY_W-1:0] victim,
    output logic [WAY_W-1:0] next_ptr
);

    always_comb begin
        victim = ptr;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[w]) victim = w[WAY_W-1:0];
        end
    end

    assign next_ptr = (ptr == WAY_W'(WAYS - 1)) ? '0 : ptr + 1'b1;

endmodule

// File: rtl/icache_sa.sv
// N-way set-associative instruction cache with in-order line fill and whole-cache flush.
// Define ICACHE_SA_PERF_EN to add saturating hit_count / miss_count outputs.
module icache_sa
    import icache_sa_pkg::*;
#(
    parameter int CACHE_SIZE = 4096,
    parameter int LINE_SIZE  = 32,
    parameter int WAYS       = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    input  logic                  flush,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_valid
`ifdef ICACHE_SA_PERF_EN
   ,output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    localparam int SET_W    = set_width(CACHE_SIZE, LINE_SIZE, WAYS);
    localparam int OFF_W    = off_width(LINE_SIZE);
    localparam int WAY_W    = way_width(WAYS);
    localparam int NUM_SETS = 1 << SET_W;
    localparam int WORDS    = 1 << OFF_W;
    localparam int TAG_W    = ADDR_WIDTH - SET_W - OFF_W - 2;

    state_t state, state_nxt;

    logic [TAG_W-1:0] r_tag;
    logic [SET_W-1:0] r_set;
    logic [OFF_W-1:0] r_off;
    logic [OFF_W-1:0] fill_cnt;
    logic [WAY_W-1:0] victim;
    logic             flush_pend;

    logic [NUM_SETS-1:0][WAYS-1:0]  valid;
    logic [NUM_SETS-1:0][WAY_W-1:0] rr_ptr;

    // Data and tags are intentionally left unreset; valid bits guard them.
    logic [TAG_W-1:0]      tags     [WAYS][NUM_SETS];
    logic [DATA_WIDTH-1:0] data_mem [WAYS][NUM_SETS*WORDS];

    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] vsel_way;
    logic [WAY_W-1:0] vsel_nxt;
    logic             accept;
    logic             last_beat;
    logic             unused_addr_lsb;

    assign unused_addr_lsb = ^req_addr[1:0];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid[r_set][w] && tags[w][r_set] == r_tag) begin
                hit     = 1'b1;
                hit_way = w[WAY_W-1:0];
            end
        end
    end

    icache_victim_sel #(
        .WAYS  (WAYS),
        .WAY_W (WAY_W)
    ) u_victim_sel (
        .valid    (valid[r_set]),
        .ptr      (rr_ptr[r_set]),
        .victim   (vsel_way),
        .next_ptr (vsel_nxt)
    );

    assign accept    = req_valid && req_ready;
    assign last_beat = (state == ST_FILL) && mem_valid && (fill_cnt == OFF_W'(WORDS - 1));
    assign mem_req   = (state == ST_FILL);
    assign mem_addr  = {r_tag, r_set, fill_cnt, 2'b00};
    assign rsp_data  = (state == ST_RESP) ? data_mem[victim][{r_set, r_off}]
                                          : data_mem[hit_way][{r_set, r_off}];

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = !flush && !flush_pend;
                if (flush || flush_pend) state_nxt = ST_FLUSH;
                else if (req_valid)      state_nxt = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                rsp_valid = hit;
                state_nxt = hit ? ST_IDLE : ST_FILL;
            end
            ST_FILL: begin
                if (last_beat) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                state_nxt = (flush || flush_pend) ? ST_FLUSH : ST_IDLE;
            end
            ST_FLUSH: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            r_tag      <= '0;
            r_set      <= '0;
            r_off      <= '0;
            fill_cnt   <= '0;
            victim     <= '0;
            flush_pend <= 1'b0;
            valid      <= '0;
            rr_ptr     <= '0;
        end else begin
            state <= state_nxt;
            if (accept) {r_tag, r_set, r_off} <= req_addr[ADDR_WIDTH-1:2];

            if (state == ST_FLUSH)                              flush_pend <= 1'b0;
            else if (flush && state != ST_IDLE)                 flush_pend <= 1'b1;

            case (state)
                ST_LOOKUP: if (!hit) begin
                    // Victim goes invalid now so a partial line is never visible.
                    victim                  <= vsel_way;
                    fill_cnt                <= '0;
                    valid[r_set][vsel_way]  <= 1'b0;
                end
                ST_FILL: if (mem_valid) begin
                    fill_cnt <= fill_cnt + 1'b1;
                    if (last_beat) begin
                        valid[r_set][victim] <= 1'b1;
                        rr_ptr[r_set]        <= vsel_nxt;
                    end
                end
                ST_FLUSH: begin
                    valid  <= '0;
                    rr_ptr <= '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_FILL && mem_valid) data_mem[victim][{r_set, fill_cnt}] <= mem_rdata;
        if (last_beat)                     tags[victim][r_set]                 <= r_tag;
    end

`ifdef ICACHE_SA_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == ST_LOOKUP) begin
            if (hit && hit_count != '1)        hit_count  <= hit_count + 1'b1;
            else if (!hit && miss_count != '1) miss_count <= miss_count + 1'b1;
        end
    end
`endif

endmodule
